// File: rtl/sparse_stream_compactor.sv
// Buffers one sparse block with its bitmask and drains the dense elements over
// successive beats, up to MAX_NUM_OUTPUT per beat, in LSB-first mask order.
module sparse_stream_compactor #(
    parameter int unsigned BITMASK_LENGTH = 16,
    parameter int unsigned ELEMENT_WIDTH  = 16,
    parameter int unsigned MAX_NUM_OUTPUT = 2,
    parameter int unsigned INDEX_BITWIDTH = 5,
    parameter int unsigned COUNT_BITWIDTH = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     ivalid,
    output logic                                     oready,
    input  logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0]  sparseInput,
    input  logic [BITMASK_LENGTH-1:0]                bitmask,
    input  logic                                     iready,
    output logic                                     ovalid,
    output logic [ELEMENT_WIDTH*MAX_NUM_OUTPUT-1:0]  denseOutput,
    output logic [COUNT_BITWIDTH-1:0]                numDenseOutput,
    output logic                                     olast
);

    localparam int unsigned EW = ELEMENT_WIDTH;
    localparam int unsigned BL = BITMASK_LENGTH;
    localparam int unsigned MO = MAX_NUM_OUTPUT;
    localparam int unsigned IW = INDEX_BITWIDTH;
    localparam int unsigned CW = COUNT_BITWIDTH;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    state_e              state_q;
    logic [EW*BL-1:0]    block_q;
    logic [BL-1:0]       mask_q;
    logic [IW-1:0]       start_idx_q;
    logic [IW-1:0]       start_idx_d;

    logic [EW*MO-1:0]    lanes_c;
    logic [CW-1:0]       cnt_c;
    logic [IW-1:0]       last_pos_c;
    logic                last_beat_c;
    logic                drain_c;

    // Pick the first MO set mask bits at or above the running start index.
    always_comb begin
        lanes_c    = '0;
        cnt_c      = '0;
        last_pos_c = '0;
        for (int i = 0; i < int'(BL); i++) begin
            if (mask_q[i] && (IW'(i) >= start_idx_q) && (cnt_c < CW'(MO))) begin
                for (int k = 0; k < int'(MO); k++) begin
                    if (cnt_c == CW'(k)) begin
                        lanes_c[k*EW +: EW] = block_q[i*EW +: EW];
                    end
                end
                cnt_c      = cnt_c + CW'(1);
                last_pos_c = IW'(i);
            end
        end
        start_idx_d = (cnt_c == '0) ? IW'(BL) : last_pos_c + IW'(1);
        last_beat_c = 1'b1;
        for (int i = 0; i < int'(BL); i++) begin
            if (mask_q[i] && (IW'(i) >= start_idx_d)) begin
                last_beat_c = 1'b0;
            end
        end
    end

    assign drain_c        = !reset && (state_q == S_DRAIN);
    assign ovalid         = drain_c;
    assign olast          = drain_c && last_beat_c;
    assign numDenseOutput = drain_c ? cnt_c : '0;
    assign denseOutput    = drain_c ? lanes_c : '0;
    // In DRAIN a new block is only taken as the final beat leaves.
    assign oready         = !reset && ((state_q == S_IDLE) || (last_beat_c && iready));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_idx_q <= '0;
            block_q     <= '0;
            mask_q      <= '0;
        end else if (ivalid && oready) begin
            block_q     <= sparseInput;
            mask_q      <= bitmask;
            start_idx_q <= '0;
            state_q     <= S_DRAIN;
        end else if ((state_q == S_DRAIN) && iready) begin
            if (last_beat_c) begin
                start_idx_q <= '0;
                state_q     <= S_IDLE;
            end else begin
                start_idx_q <= start_idx_d;
            end
        end
    end

endmodule

// File: tb/tb_sparse_stream_compactor.sv
// Directed self-checking bench for sparse_stream_compactor (EW=16, BL=16, MO=2).
module tb_sparse_stream_compactor;

    logic         clock = 1'b0;
    logic         reset;
    logic         ivalid;
    logic         oready;
    logic [255:0] sparseInput;
    logic [15:0]  bitmask;
    logic         iready;
    logic         ovalid;
    logic [31:0]  denseOutput;
    logic [1:0]   numDenseOutput;
    logic         olast;

    logic [255:0] data_a;
    logic [255:0] data_b;
    logic [35:0]  obs;
    int           checks = 0;
    int           failures = 0;

    always #5 clock = ~clock;

    sparse_stream_compactor #(
        .BITMASK_LENGTH(16), .ELEMENT_WIDTH(16), .MAX_NUM_OUTPUT(2),
        .INDEX_BITWIDTH(5), .COUNT_BITWIDTH(2)
    ) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
        .sparseInput(sparseInput), .bitmask(bitmask), .iready(iready),
        .ovalid(ovalid), .denseOutput(denseOutput),
        .numDenseOutput(numDenseOutput), .olast(olast)
    );

    assign obs = {ovalid, olast, numDenseOutput, denseOutput};

    function automatic logic [35:0] bt(input logic v, input logic l, input logic [1:0] n,
                                       input logic [15:0] a, input logic [15:0] b);
        return {v, l, n, b, a};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ivalid = 1'b0; iready = 1'b0; bitmask = '0; sparseInput = data_a;
        step(); step();
        #1;
        checks++;
        if (obs !== 36'd0 || oready !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got=%h/%b exp=0/0", obs, oready);
        end
        reset = 1'b0;
        step();
        checks++;
        if (oready !== 1'b1 || ovalid !== 1'b0) begin
            failures++; $display("FAIL reset_release oready=%b ovalid=%b exp 1/0", oready, ovalid);
        end
    endtask

    task automatic test_empty();
        ivalid = 1'b1; bitmask = 16'h0000; iready = 1'b1;
        step();
        ivalid = 1'b0; #1;
        checks++;
        if (obs !== bt(1, 1, 0, 0, 0)) begin
            failures++; $display("FAIL t1_beat got=%h exp=%h", obs, bt(1, 1, 0, 0, 0));
        end
        step();
        checks++;
        if (ovalid !== 1'b0 || oready !== 1'b1) begin
            failures++; $display("FAIL t1_idle ovalid=%b oready=%b exp 0/1", ovalid, oready);
        end
    endtask

    task automatic test_partial();
        ivalid = 1'b1; bitmask = 16'h0025; iready = 1'b1;
        step();
        ivalid = 1'b0; #1;
        checks++;
        if (obs !== bt(1, 0, 2, 16'd1, 16'd3) || oready !== 1'b0) begin
            failures++; $display("FAIL t2_beat1 got=%h/%b exp=%h/0", obs, oready, bt(1, 0, 2, 16'd1, 16'd3));
        end
        step();
        checks++;
        if (obs !== bt(1, 1, 1, 16'd6, 16'd0)) begin
            failures++; $display("FAIL t2_beat2 got=%h exp=%h", obs, bt(1, 1, 1, 16'd6, 16'd0));
        end
        step();
        checks++;
        if (ovalid !== 1'b0) begin
            failures++; $display("FAIL t2_idle ovalid=%b exp=0", ovalid);
        end
    endtask

    task automatic test_full();
        logic [35:0] exp;
        ivalid = 1'b1; bitmask = 16'hFFFF; iready = 1'b1;
        step();
        ivalid = 1'b0; #1;
        for (int k = 0; k < 8; k++) begin
            exp = bt(1, (k == 7), 2, 16'(2*k+1), 16'(2*k+2));
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL t3_beat%0d got=%h exp=%h", k, obs, exp);
            end
            step();
        end
        checks++;
        if (ovalid !== 1'b0 || oready !== 1'b1) begin
            failures++; $display("FAIL t3_idle ovalid=%b oready=%b exp 0/1", ovalid, oready);
        end
    endtask

    task automatic test_boundary();
        ivalid = 1'b1; bitmask = 16'h8001; iready = 1'b1;
        step();
        ivalid = 1'b0; #1;
        checks++;
        if (obs !== bt(1, 1, 2, 16'd1, 16'd16)) begin
            failures++; $display("FAIL t4_beat got=%h exp=%h", obs, bt(1, 1, 2, 16'd1, 16'd16));
        end
        step();
        checks++;
        if (ovalid !== 1'b0) begin
            failures++; $display("FAIL t4_idle ovalid=%b exp=0", ovalid);
        end
    endtask

    task automatic test_stall();
        logic [35:0] exp;
        int k;
        k = 0;
        ivalid = 1'b1; bitmask = 16'hFFFF; iready = 1'b1;
        step();
        ivalid = 1'b0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            iready = ((c % 3) == 0);
            #1;
            exp = bt(1, (k == 7), 2, 16'(2*k+1), 16'(2*k+2));
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL t5_cycle%0d got=%h exp=%h", c, obs, exp);
            end
            if (iready) k++;
            step();
        end
        checks++;
        if (k !== 8 || ovalid !== 1'b0) begin
            failures++; $display("FAIL t5_count beats=%0d ovalid=%b exp 8/0", k, ovalid);
        end
        iready = 1'b1;
    endtask

    task automatic test_back_to_back();
        ivalid = 1'b1; bitmask = 16'h0025; sparseInput = data_a; iready = 1'b1;
        step();
        sparseInput = data_b; bitmask = 16'h0003; #1;
        checks++;
        if (obs !== bt(1, 0, 2, 16'd1, 16'd3) || oready !== 1'b0) begin
            failures++; $display("FAIL t6_a_beat1 got=%h/%b exp=%h/0", obs, oready, bt(1, 0, 2, 16'd1, 16'd3));
        end
        step();
        checks++;
        if (obs !== bt(1, 1, 1, 16'd6, 16'd0) || oready !== 1'b1) begin
            failures++; $display("FAIL t6_a_beat2 got=%h/%b exp=%h/1", obs, oready, bt(1, 1, 1, 16'd6, 16'd0));
        end
        step();
        ivalid = 1'b0; #1;
        checks++;
        if (obs !== bt(1, 1, 2, 16'h0100, 16'h0101)) begin
            failures++; $display("FAIL t6_b_beat got=%h exp=%h", obs, bt(1, 1, 2, 16'h0100, 16'h0101));
        end
        step();
        checks++;
        if (ovalid !== 1'b0) begin
            failures++; $display("FAIL t6_idle ovalid=%b exp=0", ovalid);
        end
        sparseInput = data_a;
    endtask

    task automatic test_reset_mid_drain();
        ivalid = 1'b1; bitmask = 16'hFFFF; iready = 1'b1;
        step();
        ivalid = 1'b0;
        step();
        reset = 1'b1; #1;
        checks++;
        if (obs !== 36'd0 || oready !== 1'b0) begin
            failures++; $display("FAIL t7_in_reset got=%h/%b exp=0/0", obs, oready);
        end
        step();
        reset = 1'b0; #1;
        checks++;
        if (ovalid !== 1'b0 || oready !== 1'b1) begin
            failures++; $display("FAIL t7_after ovalid=%b oready=%b exp 0/1", ovalid, oready);
        end
        ivalid = 1'b1; bitmask = 16'h0025;
        step();
        ivalid = 1'b0; #1;
        checks++;
        if (obs !== bt(1, 0, 2, 16'd1, 16'd3)) begin
            failures++; $display("FAIL t7_new_beat1 got=%h exp=%h", obs, bt(1, 0, 2, 16'd1, 16'd3));
        end
        step();
        checks++;
        if (obs !== bt(1, 1, 1, 16'd6, 16'd0)) begin
            failures++; $display("FAIL t7_new_beat2 got=%h exp=%h", obs, bt(1, 1, 1, 16'd6, 16'd0));
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            data_a[i*16 +: 16] = 16'(i + 1);
            data_b[i*16 +: 16] = 16'(16'h0100 + i);
        end
        test_reset();
        test_empty();
        test_partial();
        test_full();
        test_boundary();
        test_stall();
        test_back_to_back();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
